// File: rtl/if_id_buffer.sv
// Two-entry fetch/decode skid FIFO with branch flush and HALT freeze.
// Optional decode-starvation counter enabled by defining IFID_BUBBLE_COUNT_EN.
module if_id_buffer #(
    parameter int unsigned            DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR   = 16'h0000,
    parameter logic [3:0]             HALT_OPCODE = 4'hF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_instruction,
    input  logic [DATA_WIDTH-1:0] in_pc_plus2,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [DATA_WIDTH-1:0] out_pc_plus2,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  halted
`ifdef IFID_BUBBLE_COUNT_EN
    ,
    output logic [15:0]           bubble_count
`endif
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned BUBBLE_W = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] instr_d [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] pc_d    [DEPTH];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    // Handshakes depend only on registered state, never on in_valid.
    assign in_ready  = (count_q != CNT_W'(DEPTH)) && (state_q == ST_RUN);
    assign out_valid = (count_q != CNT_W'(0));
    assign halted    = (state_q == ST_HALTED);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instruction = out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
    assign out_pc_plus2    = out_valid ? pc_q[rd_ptr_q]    : DATA_WIDTH'(0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= DATA_WIDTH'(0);
                pc_q[i]    <= DATA_WIDTH'(0);
            end
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
        end
    end

    // Flush overrides any same-cycle push or pop and releases a halt.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = instr_q[i];
            pc_d[i]    = pc_q[i];
        end

        if (flush) begin
            state_d  = ST_RUN;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = CNT_W'(0);
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = in_instruction;
                pc_d[wr_ptr_q]    = in_pc_plus2;
                wr_ptr_d          = ~wr_ptr_q;
                if (in_instruction[15:12] == HALT_OPCODE) begin
                    state_d = ST_HALTED;
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IFID_BUBBLE_COUNT_EN
    logic [BUBBLE_W-1:0] bubble_q, bubble_d;

    // Saturating count of cycles where decode wanted work but none was ready.
    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !out_valid && (bubble_q != {BUBBLE_W{1'b1}})) begin
            bubble_d = bubble_q + BUBBLE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_q <= BUBBLE_W'(0);
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus queues expected entries,
// a negedge monitor checks every popped head entry in order.
module tb_if_id_buffer;

    localparam int unsigned DW = 16;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_instruction;
    logic [DW-1:0] in_pc_plus2;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_instruction;
    logic [DW-1:0] out_pc_plus2;
    logic          out_ready;
    logic          flush;
    logic          halted;
`ifdef IFID_BUBBLE_COUNT_EN
    logic [15:0]   bubble_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*DW-1:0] exp_q [$];

    if_id_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_instruction  (in_instruction),
        .in_pc_plus2     (in_pc_plus2),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc_plus2    (out_pc_plus2),
        .out_ready       (out_ready),
        .flush           (flush),
        .halted          (halted)
`ifdef IFID_BUBBLE_COUNT_EN
        ,
        .bubble_count    (bubble_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Monitor: a head entry presented with out_ready and no flush is consumed at the next edge.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready && !flush) begin
            logic [2*DW-1:0] exp_e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got instr=%h pc=%h, expected no entry",
                         out_instruction, out_pc_plus2);
            end else begin
                exp_e = exp_q.pop_front();
                if ({out_instruction, out_pc_plus2} !== exp_e) begin
                    n_fail++;
                    $display("FAIL pop_data: got instr=%h pc=%h, expected instr=%h pc=%h",
                             out_instruction, out_pc_plus2, exp_e[2*DW-1:DW], exp_e[DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_push(input logic [DW-1:0] instr, input logic [DW-1:0] pc, input bit expect_accept);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc_plus2    = pc;
        if (expect_accept) exp_q.push_back({instr, pc});
    endtask

    initial begin
        reset          = 1'b0;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc_plus2    = '0;
        out_ready      = 1'b1;
        flush          = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instruction), 32'h0000);
        check("rst_out_pc", 32'(out_pc_plus2), 32'h0000);
        check("rst_halted", 32'(halted), 32'd0);
        #10 reset = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_instr", 32'(out_instruction), 32'h0000);
        check("idle_halted", 32'(halted), 32'd0);

        // Fill both entries, then drain in order.
        out_ready = 1'b0;
        drive_push(16'h1234, 16'h0002, 1'b1);
        step();
        drive_push(16'h5678, 16'h0004, 1'b1);
        step();
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head", 32'(out_instruction), 32'h1234);
        out_ready = 1'b1;
        step();
        check("drain_second", 32'(out_instruction), 32'h5678);
        check("drain_second_pc", 32'(out_pc_plus2), 32'h0004);
        step();
        check("drained_valid", 32'(out_valid), 32'd0);

        // One resident entry with push and pop every cycle across pointer wrap.
        out_ready = 1'b0;
        drive_push(16'h00A0, 16'h0100, 1'b1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_push(16'h00B0 + 16'(i), 16'h0200 + 16'(2*i), 1'b1);
            step();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Flush with two entries held and a concurrent push.
        out_ready = 1'b0;
        drive_push(16'h2222, 16'h0010, 1'b1);
        step();
        drive_push(16'h3333, 16'h0012, 1'b1);
        step();
        drive_push(16'hDEAD, 16'h0014, 1'b0);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_instr", 32'(out_instruction), 32'h0000);
        check("flush_out_pc", 32'(out_pc_plus2), 32'h0000);
        out_ready = 1'b1;
        step();
        check("flush_no_ghost", 32'(out_valid), 32'd0);

        // HALT freezes intake but still drains.
        out_ready = 1'b0;
        drive_push(16'hF000, 16'h0020, 1'b1);
        step();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        drive_push(16'h1111, 16'h0022, 1'b0);
        step();
        check("halt_head", 32'(out_instruction), 32'hF000);
        out_ready = 1'b1;
        step();
        check("halt_drained", 32'(out_valid), 32'd0);
        check("halt_still", 32'(halted), 32'd1);
        step();
        check("halt_ignored_push", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-operation discards a held entry immediately.
        out_ready = 1'b0;
        drive_push(16'h4444, 16'h0030, 1'b0);
        step();
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_instr", 32'(out_instruction), 32'h0000);
        #1 reset = 1'b1;

`ifdef IFID_BUBBLE_COUNT_EN
        step();
        reset = 1'b0;
        #1;
        check("bubble_rst", 32'(bubble_count), 32'd0);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        check("bubble_five", 32'(bubble_count), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("bubble_flush_keeps", 32'(bubble_count), 32'd5);
        reset = 1'b0;
        #1;
        check("bubble_reset_clears", 32'(bubble_count), 32'd0);
        #1 reset = 1'b1;
`endif

        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
